// File: rtl/gate_unit_arbiter_pkg.sv
// Shared opcodes, FSM state encoding and sizing limits for the gate-unit arbiter
// and the gate_lanes datapath that other blocks also reuse.
package gate_unit_arbiter_pkg;

    localparam logic [2:0] OP_AND     = 3'd0;
    localparam logic [2:0] OP_OR      = 3'd1;
    localparam logic [2:0] OP_NAND    = 3'd2;
    localparam logic [2:0] OP_NOR     = 3'd3;
    localparam logic [2:0] OP_XOR     = 3'd4;
    localparam logic [2:0] OP_XNOR    = 3'd5;
    localparam logic [2:0] OP_NOT     = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    localparam int OP_W = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/gate_unit_arbiter_gate_lanes.sv
// Combinational WIDTH-bit gate unit: each bit lane computes every gate function,
// then the opcode selects one. Illegal opcodes yield zero data and raise err.
module gate_lanes
    import gate_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic and_s, or_s, xor_s, not_s, lane_y_s;

        assign and_s = a[i] & b[i];
        assign or_s  = a[i] | b[i];
        assign xor_s = a[i] ^ b[i];
        assign not_s = ~a[i];

        // Per-lane opcode mux over the precomputed gate functions.
        always_comb begin
            lane_y_s = 1'b0;
            case (op)
                OP_AND:  lane_y_s = and_s;
                OP_OR:   lane_y_s = or_s;
                OP_NAND: lane_y_s = ~and_s;
                OP_NOR:  lane_y_s = ~or_s;
                OP_XOR:  lane_y_s = xor_s;
                OP_XNOR: lane_y_s = ~xor_s;
                OP_NOT:  lane_y_s = not_s;
                default: lane_y_s = 1'b0;
            endcase
        end

        assign y[i] = lane_y_s;
    end

    // Error flag is raised only for the reserved opcode.
    always_comb begin
        if (op == OP_ILLEGAL) begin
            err = 1'b1;
        end else begin
            err = 1'b0;
        end
    end

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one gate_lanes unit among NREQ requesters, with
// valid/ready handshakes on both sides and an ID-tagged registered response.
module gate_unit_arbiter
    import gate_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [OP_W*NREQ-1:0]  req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic                  busy
);

    state_t           state_r, state_next_s;
    logic [IDW-1:0]   rr_ptr_r;
    logic [IDW-1:0]   id_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r;
    logic             rsp_valid_r, rsp_err_r, busy_r;
    logic [IDW-1:0]   rsp_id_r;
    logic [WIDTH-1:0] rsp_data_r;

    logic             grant_found_s;
    logic [IDW-1:0]   grant_id_s;
    logic [WIDTH-1:0] lane_y_s;
    logic             lane_err_s;

    gate_lanes #(.WIDTH(WIDTH)) u_gate_lanes (
        .a   (a_r),
        .b   (b_r),
        .op  (op_r),
        .y   (lane_y_s),
        .err (lane_err_s)
    );

    // Round-robin search: first valid requester at or above rr_ptr, wrapping mod NREQ.
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = {IDW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(rr_ptr_r) + k) % NREQ;
            if (!grant_found_s && req_valid[idx]) begin
                grant_found_s = 1'b1;
                grant_id_s    = IDW'(idx);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Accept is combinational so the requester sees it in the cycle it is granted.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        if (!rst && (state_r == S_IDLE) && grant_found_s) begin
            req_ready[grant_id_s] = 1'b1;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    // Next-state logic for the IDLE -> EXEC -> RESP -> IDLE sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (grant_found_s) begin
                    state_next_s = S_EXEC;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_EXEC: state_next_s = S_RESP;
            S_RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_RESP;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // State, capture and response registers; reset drops any in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            rr_ptr_r    <= {IDW{1'b0}};
            id_r        <= {IDW{1'b0}};
            op_r        <= 3'd0;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {IDW{1'b0}};
            rsp_data_r  <= {WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != S_IDLE);
            case (state_r)
                S_IDLE: begin
                    if (grant_found_s) begin
                        id_r <= grant_id_s;
                        op_r <= req_op[OP_W*grant_id_s +: OP_W];
                        a_r  <= req_a[WIDTH*grant_id_s +: WIDTH];
                        b_r  <= req_b[WIDTH*grant_id_s +: WIDTH];
                    end
                end
                S_EXEC: begin
                    rsp_valid_r <= 1'b1;
                    rsp_id_r    <= id_r;
                    rsp_data_r  <= lane_y_s;
                    rsp_err_r   <= lane_err_s;
                end
                S_RESP: begin
                    if (rsp_valid_r && rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        // Explicit wrap keeps non-power-of-two NREQ from yielding ids >= NREQ.
                        if (id_r == IDW'(NREQ - 1)) begin
                            rr_ptr_r <= {IDW{1'b0}};
                        end else begin
                            rr_ptr_r <= id_r + IDW'(1);
                        end
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Directed bench for gate_unit_arbiter (WIDTH=8, NREQ=4): reset, single op,
// all opcodes, round-robin order, backpressure, and reset mid-transaction.
module tb_gate_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [11:0] req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        busy;

    int n_vec  = 0;
    int n_miss = 0;

    gate_unit_arbiter #(.WIDTH(8), .NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_port(input int port, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[3*port +: 3] = op;
        req_a[8*port +: 8]  = a;
        req_b[8*port +: 8]  = b;
    endtask

    // One request from a single port (all others idle), full handshake with rsp_ready=1.
    task automatic do_txn(input int port, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_data, input logic exp_err);
        logic [3:0] onehot;
        onehot = 4'b0001 << port;
        @(negedge clk);
        set_port(port, op, a, b);
        req_valid = onehot;
        #1;
        chk("txn_req_ready", 32'(req_ready), 32'(onehot));
        @(negedge clk);
        req_valid = 4'b0000;
        chk("txn_exec_busy", 32'(busy), 32'd1);
        chk("txn_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("txn_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("txn_rsp_id", 32'(rsp_id), 32'(port));
        chk("txn_rsp_data", 32'(rsp_data), 32'(exp_data));
        chk("txn_rsp_err", 32'(rsp_err), 32'(exp_err));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("txn_done_valid", 32'(rsp_valid), 32'd0);
        chk("txn_done_busy", 32'(busy), 32'd0);
    endtask

    logic [7:0] all_exp [0:7];
    logic [7:0] rr_exp  [0:3];
    int         rr_ord  [0:5];
    logic [7:0] held_data;

    initial begin
        all_exp = '{8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h5A, 8'h00};
        rr_exp  = '{8'hFA, 8'hEA, 8'hDA, 8'hCA};
        rr_ord  = '{0, 1, 2, 3, 0, 1};

        rst       = 1'b1;
        req_valid = 4'hF;
        req_op    = 12'h000;
        req_a     = 32'h0000_0000;
        req_b     = 32'h0000_0000;
        rsp_ready = 1'b0;

        // 1. Reset with every requester asserting.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        rst = 1'b0;
        #1;
        chk("first_grant_port0", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = 4'h0;
        @(negedge clk);
        chk("first_rsp_id", 32'(rsp_id), 32'd0);
        chk("first_rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("first_done_busy", 32'(busy), 32'd0);

        // 2. Single XOR from port 2.
        do_txn(2, 3'd4, 8'hF0, 8'h3C, 8'hCC, 1'b0);

        // 3. Every opcode from port 0.
        for (int op = 0; op < 8; op++) begin
            do_txn(0, 3'(op), 8'hA5, 8'h0F, all_exp[op], (op == 7) ? 1'b1 : 1'b0);
        end

        // Port 3 transaction leaves rr_ptr at 0 (wrap from NREQ-1).
        do_txn(3, 3'd1, 8'h12, 8'h34, 8'h36, 1'b0);

        // 4. Round-robin with all ports requesting continuously.
        for (int p = 0; p < 4; p++) begin
            set_port(p, 3'd4, {4'(p), 4'h5}, 8'hFF);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int t = 0; t < 6; t++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(4'b0001 << rr_ord[t]));
            @(negedge clk);
            @(negedge clk);
            chk("rr_rsp_id", 32'(rsp_id), 32'(rr_ord[t]));
            chk("rr_rsp_data", 32'(rsp_data), 32'(rr_exp[rr_ord[t]]));
            @(negedge clk);
        end
        req_valid = 4'h0;
        rsp_ready = 1'b0;

        // 5. Backpressure: port 1 NAND, then hold rsp_ready low with everyone requesting.
        @(negedge clk);
        set_port(1, 3'd2, 8'hF0, 8'hCC);
        req_valid = 4'b0010;
        #1;
        chk("bp_grant", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = 4'hF;
        @(negedge clk);
        held_data = 8'h3F;
        for (int c = 0; c < 10; c++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(rsp_data), 32'(held_data));
            chk("bp_rsp_id", 32'(rsp_id), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_release_busy", 32'(busy), 32'd0);
        #1;
        chk("bp_next_grant", 32'(req_ready), 32'b0100);
        req_valid = 4'h0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("drop_no_rsp", 32'(rsp_valid), 32'd0);
            chk("drop_idle", 32'(busy), 32'd0);
        end

        // 6. Reset while in EXEC.
        set_port(3, 3'd0, 8'hFF, 8'hFF);
        req_valid = 4'b1000;
        #1;
        chk("mid_grant", 32'(req_ready), 32'b1000);
        @(negedge clk);
        req_valid = 4'h0;
        chk("mid_exec_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_no_stale", 32'(rsp_valid), 32'd0);
        end
        req_valid = 4'b1010;
        #1;
        chk("mid_ptr_reset", 32'(req_ready), 32'b0010);
        req_valid = 4'h0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
